// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants one of four execution-unit completions per cycle and drives the registered CDB.
// Build option CDB_ARB_FIXED_PRIORITY_EN selects fixed div > mul > ld_st > int priority instead of round-robin.
module cdb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  req_int,
    input  logic                  req_ld_st,
    input  logic                  req_mul,
    input  logic                  req_div,
    input  logic [TAG_WIDTH-1:0]  tag_int,
    input  logic [TAG_WIDTH-1:0]  tag_ld_st,
    input  logic [TAG_WIDTH-1:0]  tag_mul,
    input  logic [TAG_WIDTH-1:0]  tag_div,
    input  logic [DATA_WIDTH-1:0] data_int,
    input  logic [DATA_WIDTH-1:0] data_ld_st,
    input  logic [DATA_WIDTH-1:0] data_mul,
    input  logic [DATA_WIDTH-1:0] data_div,
    input  logic                  branch_int,
    input  logic                  branch_taken_int,
    output logic                  grant_int,
    output logic                  grant_ld_st,
    output logic                  grant_mul,
    output logic                  grant_div,
    output logic                  CDB_valid,
    output logic [TAG_WIDTH-1:0]  CDB_tag,
    output logic [DATA_WIDTH-1:0] CDB_data,
    output logic                  CDB_branch,
    output logic                  CDB_branch_taken
);

    logic [3:0]            req_vec_s;
    logic [3:0]            grant_vec_s;
    logic [1:0]            win_idx_s;
    logic                  win_any_s;
    logic                  grant_en_s;
    logic [TAG_WIDTH-1:0]  win_tag_s;
    logic [DATA_WIDTH-1:0] win_data_s;
    logic                  cdb_valid_r;
    logic [TAG_WIDTH-1:0]  cdb_tag_r;
    logic [DATA_WIDTH-1:0] cdb_data_r;
    logic                  cdb_branch_r;
    logic                  cdb_branch_taken_r;

    assign req_vec_s = {req_div, req_mul, req_ld_st, req_int};

`ifdef CDB_ARB_FIXED_PRIORITY_EN
    // Fixed priority: scanning upward lets the highest requesting index overwrite lower ones.
    always_comb begin
        win_idx_s = 2'd0;
        win_any_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            win_idx_s = req_vec_s[i] ? 2'(i) : win_idx_s;
            win_any_s = win_any_s | req_vec_s[i];
        end
    end
`else
    logic [1:0] rr_ptr_r;
    logic [1:0] cand_s;

    // Round-robin search: scan from farthest to nearest so the candidate at rr_ptr is applied last and wins.
    always_comb begin
        win_idx_s = 2'd0;
        win_any_s = 1'b0;
        cand_s    = rr_ptr_r;
        for (int k = 3; k >= 0; k--) begin
            cand_s    = rr_ptr_r + 2'(k);
            win_idx_s = req_vec_s[cand_s] ? cand_s : win_idx_s;
            win_any_s = win_any_s | req_vec_s[cand_s];
        end
    end

    // Pointer moves just past the winner; holds when nothing is granted (including flush).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_r <= 2'd0;
        end else if (grant_en_s) begin
            rr_ptr_r <= win_idx_s + 2'd1;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    // Grants are suppressed while in reset and on flush.
    assign grant_en_s  = reset & ~flush & win_any_s;
    assign grant_vec_s = grant_en_s ? (4'b0001 << win_idx_s) : 4'b0000;
    assign grant_int   = grant_vec_s[0];
    assign grant_ld_st = grant_vec_s[1];
    assign grant_mul   = grant_vec_s[2];
    assign grant_div   = grant_vec_s[3];

    // Payload select for the winning unit.
    always_comb begin
        win_tag_s  = tag_int;
        win_data_s = data_int;
        case (win_idx_s)
            2'd0: begin win_tag_s = tag_int;   win_data_s = data_int;   end
            2'd1: begin win_tag_s = tag_ld_st; win_data_s = data_ld_st; end
            2'd2: begin win_tag_s = tag_mul;   win_data_s = data_mul;   end
            2'd3: begin win_tag_s = tag_div;   win_data_s = data_div;   end
            default: begin win_tag_s = tag_int; win_data_s = data_int; end
        endcase
    end

    // CDB beat register: tag/data hold across idle cycles, consumers qualify on valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_valid_r        <= 1'b0;
            cdb_tag_r          <= '0;
            cdb_data_r         <= '0;
            cdb_branch_r       <= 1'b0;
            cdb_branch_taken_r <= 1'b0;
        end else if (grant_en_s) begin
            cdb_valid_r        <= 1'b1;
            cdb_tag_r          <= win_tag_s;
            cdb_data_r         <= win_data_s;
            cdb_branch_r       <= (win_idx_s == 2'd0) & branch_int;
            cdb_branch_taken_r <= (win_idx_s == 2'd0) & branch_taken_int;
        end else begin
            cdb_valid_r        <= 1'b0;
            cdb_tag_r          <= cdb_tag_r;
            cdb_data_r         <= cdb_data_r;
            cdb_branch_r       <= 1'b0;
            cdb_branch_taken_r <= 1'b0;
        end
    end

    assign CDB_valid        = cdb_valid_r;
    assign CDB_tag          = cdb_tag_r;
    assign CDB_data         = cdb_data_r;
    assign CDB_branch       = cdb_branch_r;
    assign CDB_branch_taken = cdb_branch_taken_r;

endmodule
